// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - repeating MSB-first serial frame transmitter with idle gaps
module serial_pattern_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [3:0]       count,
    input  logic [3:0]       gap,
    output logic             sout,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] MSB = IW'(WIDTH - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] word, word_n;
    logic [3:0]       frames_left, frames_left_n;
    logic [3:0]       gap_len, gap_len_n;
    logic [3:0]       gap_cnt, gap_cnt_n;
    logic [IW-1:0]    idx, idx_n;
    logic [IW-1:0]    idx_m1;
    logic             sout_n, bit_valid_n, busy_n, done_n;

    assign idx_m1 = idx - IW'(1);

    always_comb begin
        state_n       = state;
        word_n        = word;
        frames_left_n = frames_left;
        gap_len_n     = gap_len;
        gap_cnt_n     = gap_cnt;
        idx_n         = idx;
        sout_n        = sout;
        bit_valid_n   = bit_valid;
        busy_n        = busy;
        done_n        = 1'b0;

        case (state)
            IDLE: begin
                sout_n      = 1'b0;
                bit_valid_n = 1'b0;
                busy_n      = 1'b0;
                if (start) begin
                    word_n        = data;
                    frames_left_n = (count == 4'd0) ? 4'd1 : count;
                    gap_len_n     = gap;
                    sout_n        = data[WIDTH-1];
                    bit_valid_n   = 1'b1;
                    busy_n        = 1'b1;
                    idx_n         = MSB;
                    state_n       = SHIFT;
                end
            end
            SHIFT: begin
                if (idx != '0) begin
                    idx_n  = idx_m1;
                    sout_n = word[idx_m1];
                end else begin
                    // Last bit of a frame: finish, chain the next frame directly, or insert a gap
                    frames_left_n = frames_left - 4'd1;
                    if (frames_left == 4'd1) begin
                        state_n     = IDLE;
                        sout_n      = 1'b0;
                        bit_valid_n = 1'b0;
                        busy_n      = 1'b0;
                        done_n      = 1'b1;
                    end else if (gap_len == 4'd0) begin
                        idx_n  = MSB;
                        sout_n = word[WIDTH-1];
                    end else begin
                        state_n     = GAP;
                        sout_n      = 1'b0;
                        bit_valid_n = 1'b0;
                        gap_cnt_n   = gap_len - 4'd1;
                    end
                end
            end
            GAP: begin
                sout_n = 1'b0;
                if (gap_cnt == 4'd0) begin
                    state_n     = SHIFT;
                    sout_n      = word[WIDTH-1];
                    bit_valid_n = 1'b1;
                    idx_n       = MSB;
                end else begin
                    gap_cnt_n = gap_cnt - 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            word        <= '0;
            frames_left <= '0;
            gap_len     <= '0;
            gap_cnt     <= '0;
            idx         <= '0;
            sout        <= 1'b0;
            bit_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            word        <= word_n;
            frames_left <= frames_left_n;
            gap_len     <= gap_len_n;
            gap_cnt     <= gap_cnt_n;
            idx         <= idx_n;
            sout        <= sout_n;
            bit_valid   <= bit_valid_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb/tb_serial_pattern_tx.sv - directed bench for serial_pattern_tx
module tb_serial_pattern_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] data = 4'd0;
    logic [3:0] count = 4'd0;
    logic [3:0] gap = 4'd0;
    logic       sout, bit_valid, busy, done;

    int checks = 0;
    int errors = 0;
    int det = 0;
    int busy_cycles = 0;
    logic [3:0] hist = 4'd0;

    serial_pattern_tx #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .data(data), .count(count), .gap(gap),
        .sout(sout), .bit_valid(bit_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Advance one edge and sample; also runs a reference 1101 detector on sout
    task automatic tick();
        @(posedge clk);
        #1;
        hist = {hist[2:0], sout};
        if (hist == 4'b1101) det++;
        if (busy) busy_cycles++;
    endtask

    // Compares {sout, bit_valid, busy, done}
    task automatic chk(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {sout, bit_valid, busy, done};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_frame(input string tag, input logic [3:0] w, input logic drop_start);
        for (int b = 3; b >= 0; b--) begin
            tick();
            if (drop_start) start = 1'b0;
            chk(tag, {w[b], 3'b110});
        end
    endtask

    task automatic expect_gap(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk(tag, 4'b0010);
        end
    endtask

    initial begin
        // Reset and idle
        tick(); chk("reset0", 4'b0000);
        tick(); chk("reset1", 4'b0000);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(); chk("idle", 4'b0000);
        end

        // Single frame 1101
        det = 0;
        data = 4'b1101; count = 4'd1; gap = 4'd0; start = 1'b1;
        expect_frame("single", 4'b1101, 1'b1);
        tick(); chk("single_done", 4'b0001);
        tick(); chk("single_after", 4'b0000);
        chk_int("single_detections", det, 1);

        // Three frames 1011 with two-bit gaps
        busy_cycles = 0;
        data = 4'b1011; count = 4'd3; gap = 4'd2; start = 1'b1;
        expect_frame("rep_f0", 4'b1011, 1'b1);
        expect_gap("rep_g0", 2);
        expect_frame("rep_f1", 4'b1011, 1'b0);
        expect_gap("rep_g1", 2);
        expect_frame("rep_f2", 4'b1011, 1'b0);
        tick(); chk("rep_done", 4'b0001);
        chk_int("rep_busy_cycles", busy_cycles, 16);
        tick(); chk("rep_after", 4'b0000);

        // count=0 treated as 1, start held high: one idle/done cycle between transfers
        det = 0;
        data = 4'b1101; count = 4'd0; gap = 4'd0; start = 1'b1;
        for (int t = 0; t < 3; t++) begin
            expect_frame("b2b_frame", 4'b1101, 1'b0);
            tick(); chk("b2b_done", 4'b0001);
        end
        start = 1'b0;
        tick(); chk("b2b_after", 4'b0000);
        chk_int("b2b_detections", det, 3);

        // Start and input changes mid-transfer are ignored
        data = 4'b1101; count = 4'd2; gap = 4'd1; start = 1'b1;
        tick(); chk("ign_b3", 4'b1110);
        data = 4'b0000; count = 4'd5; gap = 4'd3; start = 1'b1;
        tick(); chk("ign_b2", 4'b1110);
        start = 1'b0;
        tick(); chk("ign_b1", 4'b0110);
        tick(); chk("ign_b0", 4'b1110);
        expect_gap("ign_gap", 1);
        expect_frame("ign_f1", 4'b1101, 1'b0);
        tick(); chk("ign_done", 4'b0001);
        tick(); chk("ign_after", 4'b0000);

        // Reset during the third bit of a frame
        data = 4'b1011; count = 4'd1; gap = 4'd0; start = 1'b1;
        tick(); start = 1'b0; chk("rst_b3", 4'b1110);
        tick(); chk("rst_b2", 4'b0110);
        tick(); chk("rst_b1", 4'b1110);
        rst = 1'b1;
        tick(); chk("rst_abort", 4'b0000);
        rst = 1'b0;
        tick(); chk("rst_no_done", 4'b0000);
        start = 1'b1;
        expect_frame("rst_fresh", 4'b1011, 1'b1);
        tick(); chk("rst_fresh_done", 4'b0001);
        tick(); chk("rst_fresh_after", 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
